seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_mux.sv | 123 ++++++++++++
 tb/tb_seg_scan_mux.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// 4-digit multiplexed 7-segment scanner; optional anti-ghosting dead time when SCAN_BLANK_EN is defined.
// Latency: seg_out/anodo are registered and reflect the previous cycle's cnt/digit_idx.
// No backpressure: enable=0 blanks the display and freezes the scan position.
module seg_scan_mux #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] seg0,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic [6:0] seg3,
    output logic [6:0] seg_out,
    output logic [3:0] anodo,
    output logic [1:0] digit_idx,
    output logic       frame_tick
);

    localparam int            CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

`ifdef SCAN_BLANK_EN
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;
`else
    typedef enum logic [1:0] {OFF, SHOW} state_t;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          en_q;
    logic [6:0]    slot_reg;
    logic [6:0]    seg_sel;
    logic [6:0]    pat;
    logic [3:0]    sel_mask;
    logic          latch;
    logic          wrap;
    logic          in_blank;

    always_comb begin
        seg_sel = seg0;
        case (digit_idx)
            2'd0: seg_sel = seg0;
            2'd1: seg_sel = seg1;
            2'd2: seg_sel = seg2;
            2'd3: seg_sel = seg3;
            default: seg_sel = seg0;
        endcase
    end

    // Latch at slot start, and again on the first cycle after a re-enable.
    assign latch = enable && ((cnt == '0) || !en_q);
    assign pat   = latch ? seg_sel : slot_reg;
    assign wrap  = enable && (cnt == CNT_LAST);

`ifdef SCAN_BLANK_EN
    assign in_blank = (cnt < BLANK_END);
`else
    assign in_blank = 1'b0;
`endif

    always_comb begin
        sel_mask            = 4'b1111;
        sel_mask[digit_idx] = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = OFF;
        end else begin
            case (state)
                OFF: begin
`ifdef SCAN_BLANK_EN
                    state_nxt = in_blank ? BLANK : SHOW;
`else
                    state_nxt = SHOW;
`endif
                end
`ifdef SCAN_BLANK_EN
                BLANK: if (!in_blank) state_nxt = SHOW;
                SHOW:  if (in_blank)  state_nxt = BLANK;
`else
                SHOW:  state_nxt = SHOW;
`endif
                default: state_nxt = OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            digit_idx  <= 2'd0;
            en_q       <= 1'b0;
            slot_reg   <= 7'b1111111;
            frame_tick <= 1'b0;
            seg_out    <= 7'b1111111;
            anodo      <= 4'b1111;
        end else begin
            en_q       <= enable;
            frame_tick <= wrap && (digit_idx == 2'd3);
            if (latch) slot_reg <= seg_sel;
            if (enable) cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) digit_idx <= digit_idx + 2'd1;
            // Outputs follow the mode this cycle's cnt selects, so they lag cnt by one clock.
            seg_out <= (state_nxt == SHOW) ? pat : 7'b1111111;
            anodo   <= (state_nxt == SHOW) ? sel_mask : 4'b1111;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with PRESCALE=8, BLANK_CYCLES=2.
module tb_seg_scan_mux;

    localparam int P  = 8;
    localparam int BC = 2;
`ifdef SCAN_BLANK_EN
    localparam int BLK = BC;
`else
    localparam int BLK = 0;
`endif

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       ft;
        logic [1:0] idx;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [6:0] seg_in [4];
    logic [6:0] seg_out;
    logic [3:0] anodo;
    logic [1:0] digit_idx;
    logic       frame_tick;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    int         m_cnt;
    logic [1:0] m_idx;
    logic [6:0] m_slot;
    logic       m_pen;

    seg_scan_mux #(.PRESCALE(P), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .seg0(seg_in[0]), .seg1(seg_in[1]), .seg2(seg_in[2]), .seg3(seg_in[3]),
        .seg_out(seg_out), .anodo(anodo), .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Predict the outputs produced by the coming edge, queue them, then advance one cycle.
    task automatic tick();
        exp_t e;
        logic [3:0] an;
        e = '{seg: 7'b1111111, an: 4'b1111, ft: 1'b0, idx: 2'd0};
        if (!reset) begin
            m_cnt = 0; m_idx = 2'd0; m_slot = 7'b1111111; m_pen = 1'b0;
        end else if (!enable) begin
            e.idx = m_idx;
            m_pen = 1'b0;
        end else begin
            if (m_cnt == 0 || !m_pen) m_slot = seg_in[m_idx];
            if (m_cnt >= BLK) begin
                an = 4'b1111;
                an[m_idx] = 1'b0;
                e.seg = m_slot;
                e.an  = an;
            end
            e.ft = (m_cnt == P - 1) && (m_idx == 2'd3);
            if (m_cnt == P - 1) begin
                m_cnt = 0;
                m_idx = m_idx + 2'd1;
            end else begin
                m_cnt = m_cnt + 1;
            end
            e.idx = m_idx;
            m_pen = 1'b1;
        end
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        exp_t e;
        int   first_show;
        seg_in[0] = 7'b0011001; seg_in[1] = 7'b0010010;
        seg_in[2] = 7'b0000010; seg_in[3] = 7'b1111000;
        enable = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({seg_out, anodo, frame_tick, digit_idx} !== {7'b1111111, 4'b1111, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_async seg_out=%b anodo=%b ft=%b idx=%0d, expected all blank idx 0",
                     seg_out, anodo, frame_tick, digit_idx);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
        end
        reset = 1'b1;
        first_show = -1;
        for (int n = 1; n <= P; n++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL first_slot cyc=%0d got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
            if (first_show < 0 && anodo == 4'b1110) first_show = n;
        end
        checks++;
        if (first_show != BLK + 1) begin
            errors++;
            $display("FAIL first_show anodo=1110 first at slot cycle %0d, expected %0d", first_show, BLK + 1);
        end
    endtask

    task automatic test_scan();
        exp_t       e;
        int         last_ft = -1;
        int         n_ft    = 0;
        int         last_ch = -1;
        logic [3:0] prev_an = anodo;
        for (int i = 0; i < 72; i++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL scan cyc=%0d got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
            checks++;
            if ($countones(anodo) < 3) begin
                errors++;
                $display("FAIL onehot cyc=%0d anodo=%b, expected at most one bit low", cyc, anodo);
            end
            if (frame_tick) begin
                if (last_ft >= 0) begin
                    checks++;
                    if (cyc - last_ft != 4 * P) begin
                        errors++;
                        $display("FAIL frame_gap gap=%0d expected %0d", cyc - last_ft, 4 * P);
                    end
                end
                last_ft = cyc;
                n_ft++;
            end
`ifndef SCAN_BLANK_EN
            if (anodo != prev_an) begin
                if (last_ch >= 0) begin
                    checks++;
                    if (cyc - last_ch != P) begin
                        errors++;
                        $display("FAIL anodo_period gap=%0d expected %0d", cyc - last_ch, P);
                    end
                end
                last_ch = cyc;
            end
`endif
            prev_an = anodo;
        end
        checks++;
        if (n_ft < 2) begin
            errors++;
            $display("FAIL frame_count saw %0d ticks, expected at least 2", n_ft);
        end
    endtask

    task automatic test_midslot_change();
        exp_t e;
        logic first = 1'b1;
        int   n_new = 0;
        for (int i = 0; i < 40 && !(m_cnt == 4 && m_idx == 2'd1); i++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL pre_change cyc=%0d got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
        end
        seg_in[1] = 7'b0000000;
        for (int i = 0; i < 40; i++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL mid_change cyc=%0d got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
            if (anodo == 4'b1011) first = 1'b0;
            if (anodo == 4'b1101) begin
                checks++;
                if (seg_out !== (first ? 7'b0010010 : 7'b0000000)) begin
                    errors++;
                    $display("FAIL slot_hold cyc=%0d seg_out=%b expected %b",
                             cyc, seg_out, first ? 7'b0010010 : 7'b0000000);
                end
                if (!first) n_new++;
            end
        end
        checks++;
        if (n_new == 0) begin
            errors++;
            $display("FAIL new_pattern 0000000 shown %0d times on digit 1, expected at least 1", n_new);
        end
    endtask

    task automatic test_enable_gap();
        exp_t e;
        int   n_adv = -1;
        for (int i = 0; i < 40 && !(m_cnt == 6 && m_idx == 2'd2); i++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL pre_gap cyc=%0d got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== {7'b1111111, 4'b1111, 1'b0, 2'd2}
                || {seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL gap cyc=%0d got %b/%b/%b/%0d expected blank idx 2 (model %b/%b/%b/%0d)",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
        end
        enable = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL resume cyc=%0d got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
            if (n_adv < 0 && digit_idx == 2'd3) n_adv = n;
        end
        checks++;
        if (n_adv != 2) begin
            errors++;
            $display("FAIL resume_len slot 2 finished after %0d cycles, expected 2", n_adv);
        end
    endtask

    task automatic test_wrap_priority();
        exp_t       e;
        logic [1:0] held;
        for (int i = 0; i < 16 && m_cnt != P - 1; i++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL pre_wrap cyc=%0d got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
        end
        held   = m_idx;
        enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) enable = 1'b1;
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL wrap_prio cyc=%0d got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
            if (i == 0) begin
                checks++;
                if (digit_idx !== held) begin
                    errors++;
                    $display("FAIL wrap_hold digit_idx=%0d expected %0d", digit_idx, held);
                end
            end
        end
    endtask

    task automatic test_reset_midslot();
        exp_t e;
        int   first_an = -1;
        for (int i = 0; i < 40 && !(m_cnt == 6 && m_idx == 2'd3); i++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL pre_rst cyc=%0d got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({seg_out, anodo, frame_tick, digit_idx} !== {7'b1111111, 4'b1111, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL rst_mid seg_out=%b anodo=%b ft=%b idx=%0d, expected all blank idx 0",
                     seg_out, anodo, frame_tick, digit_idx);
        end
        tick();
        void'(q.pop_front());
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({seg_out, anodo, frame_tick, digit_idx} !== e) begin
                errors++;
                $display("FAIL post_rst cyc=%0d got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, seg_out, anodo, frame_tick, digit_idx, e.seg, e.an, e.ft, e.idx);
            end
            if (first_an < 0 && anodo != 4'b1111) first_an = int'(anodo);
        end
        checks++;
        if (first_an != 32'(4'b1110)) begin
            errors++;
            $display("FAIL restart_digit first lit anodo=%0h expected e", first_an);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midslot_change();
        test_enable_gap();
        test_wrap_priority();
        test_reset_midslot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
